// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_types_pkg
// Description : Shared CPU types: the machine word, the unified-RAM handshake
//               state, and the RAM arbiter's grant state.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // Handshake state reported by the unified RAM each cycle.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Which requester currently owns the RAM bus.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arb_state_t;

endpackage : cpu_types_pkg
`default_nettype wire

// File: rtl/ram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter_if
// Description : Bundle of every signal crossing the RAM arbiter boundary.
//               The arb modport is the arbiter's view; the tb modport is the
//               view of whatever drives the requesters and models the RAM.
// Ports       : CLK - system clock shared by both sides
// Revision    : 1.0 - initial release
// ============================================================================
interface ram_arbiter_if
  import cpu_types_pkg::*;
(
  input logic CLK
);

  logic      sRST;
  logic      iREN;
  word_t     iaddr;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  ramstate_t ramstate;
  word_t     ramload;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  logic      iwait;
  logic      dwait;
  word_t     iload;
  word_t     dload;
  logic      rambusy;
  logic      memfault;

  modport arb (
    input  CLK, sRST, iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
    output ramREN, ramWEN, ramaddr, ramstore, iwait, dwait, iload, dload,
           rambusy, memfault
  );

  modport tb (
    input  CLK, ramREN, ramWEN, ramaddr, ramstore, iwait, dwait, iload, dload,
           rambusy, memfault,
    output sRST, iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload
  );

endinterface : ram_arbiter_if
`default_nettype wire

// File: rtl/streak_counter.sv
`default_nettype none
// ============================================================================
// Module      : streak_counter
// Description : Saturating up-counter with synchronous clear. Clear wins over
//               increment; the count sticks at MAX_COUNT.
// Ports       : CLK      - clock
//               sRST     - synchronous active-high reset (count -> 0)
//               inc_i    - increment request
//               clr_i    - clear request
//               count_o  - current count
// Revision    : 1.0 - initial release
// ============================================================================
module streak_counter #(
  parameter int MAX_COUNT = 4,
  parameter int WIDTH     = $clog2(MAX_COUNT + 1)
) (
  input  logic             CLK,
  input  logic             sRST,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] count_o
);

  localparam logic [WIDTH-1:0] c_max_count = WIDTH'(MAX_COUNT);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != c_max_count)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (sRST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule : streak_counter
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter
// Description : Shares the single-port unified RAM between instruction fetch
//               and data memory. One requester owns the bus at a time until
//               the RAM answers ACCESS or ERROR. Data wins arbitration, but
//               after MAX_DSTREAK data completions with a fetch pending the
//               fetch is forced through.
// Ports       : CLK/sRST                 - clock, sync active-high reset
//               iREN/iaddr               - instruction read request
//               dREN/dWEN/daddr/dstore   - data read/write request
//               ramstate/ramload         - RAM handshake and read data
//               ramREN/ramWEN/ramaddr/ramstore - RAM bus
//               iwait/iload, dwait/dload - per-side completion and data
//               rambusy                  - a grant is active (hazard unit)
//               memfault                 - RAM reported ERROR during a grant
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter
  import cpu_types_pkg::*;
#(
  parameter int MAX_DSTREAK = 4
) (
  input  logic      CLK,
  input  logic      sRST,
  input  logic      iREN,
  input  word_t     iaddr,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  input  ramstate_t ramstate,
  input  word_t     ramload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  output logic      iwait,
  output logic      dwait,
  output word_t     iload,
  output word_t     dload,
  output logic      rambusy,
  output logic      memfault
);

  localparam int                  c_streak_w   = $clog2(MAX_DSTREAK + 1);
  localparam logic [c_streak_w-1:0] c_streak_max = c_streak_w'(MAX_DSTREAK);

  arb_state_t              state_q;
  arb_state_t              state_d;
  logic [c_streak_w-1:0]   w_streak;

  logic w_dreq;
  logic w_access;
  logic w_error;
  logic w_i_done;
  logic w_d_done;
  logic w_d_allowed;
  logic w_streak_inc;
  logic w_streak_clr;

  assign w_dreq   = dREN | dWEN;
  assign w_access = (ramstate == ACCESS);
  assign w_error  = (ramstate == ERROR);
  assign w_i_done = (state_q == IGRANT) & w_access;
  assign w_d_done = (state_q == DGRANT) & w_access;

  // Data may win from IDLE unless it has already taken its full streak
  // while a fetch was waiting.
  assign w_d_allowed = w_dreq & ((w_streak < c_streak_max) | ~iREN);

  // The streak only grows while fetch is actually being held off.
  assign w_streak_inc = w_d_done & iREN;
  assign w_streak_clr = w_i_done | (w_d_done & ~iREN);

  streak_counter #(
    .MAX_COUNT (MAX_DSTREAK),
    .WIDTH     (c_streak_w)
  ) u_streak (
    .CLK     (CLK),
    .sRST    (sRST),
    .inc_i   (w_streak_inc),
    .clr_i   (w_streak_clr),
    .count_o (w_streak)
  );

  // --------------------------------------------------------------------------
  // Next-state: on completion the finished side is masked out, so the other
  // side's pending request is entered directly without an IDLE bubble.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (w_d_allowed) begin
          state_d = DGRANT;
        end else if (iREN) begin
          state_d = IGRANT;
        end else begin
          state_d = IDLE;
        end
      end
      IGRANT: begin
        if (w_error) begin
          state_d = IDLE;
        end else if (w_access) begin
          state_d = w_dreq ? DGRANT : IDLE;
        end else if (!iREN) begin
          state_d = IDLE;
        end
      end
      DGRANT: begin
        if (w_error) begin
          state_d = IDLE;
        end else if (w_access) begin
          state_d = iREN ? IGRANT : IDLE;
        end else if (!w_dreq) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (sRST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // RAM bus: selected by the grant state; the owner's live address/data are
  // passed through since requesters hold them stable until their wait drops.
  // --------------------------------------------------------------------------
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    unique case (state_q)
      IGRANT: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
      end
      DGRANT: begin
        // A simultaneous read+write request is treated as a write.
        ramREN   = dREN & ~dWEN;
        ramWEN   = dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
      end
      default: begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
      end
    endcase
  end

  // Completion is visible in the same cycle the RAM reports ACCESS.
  assign iwait    = iREN & ~w_i_done;
  assign dwait    = w_dreq & ~w_d_done;
  assign iload    = w_i_done ? ramload : '0;
  assign dload    = w_d_done ? ramload : '0;
  assign rambusy  = (state_q != IDLE);
  assign memfault = ~sRST & rambusy & w_error;

endmodule : ram_arbiter
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_arbiter
// Description : Self-checking bench for ram_arbiter: directed scenarios plus
//               a randomized run compared against a cycle-level reference
//               model of the arbitration rules.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;
  import cpu_types_pkg::*;

  localparam int MAXD = 4;

  logic clk;
  int   tests_run    = 0;
  int   tests_failed = 0;

  ram_arbiter_if bus (.CLK(clk));

  ram_arbiter #(.MAX_DSTREAK(MAXD)) dut (
    .CLK      (clk),
    .sRST     (bus.sRST),
    .iREN     (bus.iREN),
    .iaddr    (bus.iaddr),
    .dREN     (bus.dREN),
    .dWEN     (bus.dWEN),
    .daddr    (bus.daddr),
    .dstore   (bus.dstore),
    .ramstate (bus.ramstate),
    .ramload  (bus.ramload),
    .ramREN   (bus.ramREN),
    .ramWEN   (bus.ramWEN),
    .ramaddr  (bus.ramaddr),
    .ramstore (bus.ramstore),
    .iwait    (bus.iwait),
    .dwait    (bus.dwait),
    .iload    (bus.iload),
    .dload    (bus.dload),
    .rambusy  (bus.rambusy),
    .memfault (bus.memfault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs change on the falling edge; outputs are checked 1 time unit later.
  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    bus.iREN = 1'b1; bus.iaddr = 32'h10; bus.dREN = 1'b1; bus.daddr = 32'h20;
    bus.dstore = 32'h55AA55AA; bus.ramstate = ACCESS; bus.ramload = 32'h1234;
    #1;
    tests_run++; if (bus.ramREN !== 1'b0) begin tests_failed++; $display("FAIL reset_ramREN got %b want 0", bus.ramREN); end
    tests_run++; if (bus.ramWEN !== 1'b0) begin tests_failed++; $display("FAIL reset_ramWEN got %b want 0", bus.ramWEN); end
    tests_run++; if (bus.ramaddr !== 32'h0) begin tests_failed++; $display("FAIL reset_ramaddr got %h want 0", bus.ramaddr); end
    tests_run++; if (bus.ramstore !== 32'h0) begin tests_failed++; $display("FAIL reset_ramstore got %h want 0", bus.ramstore); end
    tests_run++; if (bus.iload !== 32'h0) begin tests_failed++; $display("FAIL reset_iload got %h want 0", bus.iload); end
    tests_run++; if (bus.dload !== 32'h0) begin tests_failed++; $display("FAIL reset_dload got %h want 0", bus.dload); end
    tests_run++; if (bus.rambusy !== 1'b0) begin tests_failed++; $display("FAIL reset_rambusy got %b want 0", bus.rambusy); end
    tests_run++; if (bus.memfault !== 1'b0) begin tests_failed++; $display("FAIL reset_memfault got %b want 0", bus.memfault); end
    tests_run++; if (bus.iwait !== 1'b1) begin tests_failed++; $display("FAIL reset_iwait got %b want 1", bus.iwait); end
    tests_run++; if (bus.dwait !== 1'b1) begin tests_failed++; $display("FAIL reset_dwait got %b want 1", bus.dwait); end
    next_cycle();
    #1;
    tests_run++; if (bus.rambusy !== 1'b0) begin tests_failed++; $display("FAIL reset_hold_rambusy got %b want 0", bus.rambusy); end
    bus.iREN = 1'b0; bus.dREN = 1'b0; bus.ramstate = FREE; bus.sRST = 1'b0;
  endtask

  task automatic test_fetch_only();
    @(negedge clk);
    bus.iREN = 1'b1; bus.iaddr = 32'h40; bus.ramstate = FREE;
    #1;
    tests_run++; if (bus.iwait !== 1'b1) begin tests_failed++; $display("FAIL fetch_c0_iwait got %b want 1", bus.iwait); end
    next_cycle();
    bus.ramstate = BUSY;
    #1;
    tests_run++; if (bus.ramREN !== 1'b1) begin tests_failed++; $display("FAIL fetch_c1_ramREN got %b want 1", bus.ramREN); end
    tests_run++; if (bus.ramaddr !== 32'h40) begin tests_failed++; $display("FAIL fetch_c1_ramaddr got %h want 40", bus.ramaddr); end
    tests_run++; if (bus.iwait !== 1'b1) begin tests_failed++; $display("FAIL fetch_c1_iwait got %b want 1", bus.iwait); end
    next_cycle();
    bus.ramstate = ACCESS; bus.ramload = 32'h8C010004;
    #1;
    tests_run++; if (bus.iwait !== 1'b0) begin tests_failed++; $display("FAIL fetch_c2_iwait got %b want 0", bus.iwait); end
    tests_run++; if (bus.iload !== 32'h8C010004) begin tests_failed++; $display("FAIL fetch_c2_iload got %h want 8c010004", bus.iload); end
    next_cycle();
    bus.iREN = 1'b0; bus.ramstate = FREE;
    #1;
    tests_run++; if (bus.rambusy !== 1'b0) begin tests_failed++; $display("FAIL fetch_c3_rambusy got %b want 0", bus.rambusy); end
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    bus.iREN = 1'b1; bus.iaddr = 32'h200; bus.dREN = 1'b1; bus.daddr = 32'h100;
    next_cycle();
    bus.ramstate = ACCESS; bus.ramload = 32'hCAFE0001;
    #1;
    tests_run++; if (bus.ramaddr !== 32'h100) begin tests_failed++; $display("FAIL simul_d_ramaddr got %h want 100", bus.ramaddr); end
    tests_run++; if (bus.dwait !== 1'b0) begin tests_failed++; $display("FAIL simul_d_dwait got %b want 0", bus.dwait); end
    tests_run++; if (bus.dload !== 32'hCAFE0001) begin tests_failed++; $display("FAIL simul_d_dload got %h want cafe0001", bus.dload); end
    tests_run++; if (bus.iwait !== 1'b1) begin tests_failed++; $display("FAIL simul_d_iwait got %b want 1", bus.iwait); end
    next_cycle();
    bus.dREN = 1'b0; bus.ramstate = BUSY;
    #1;
    tests_run++; if (bus.ramaddr !== 32'h200) begin tests_failed++; $display("FAIL simul_i_ramaddr got %h want 200", bus.ramaddr); end
    tests_run++; if (bus.ramREN !== 1'b1) begin tests_failed++; $display("FAIL simul_i_ramREN got %b want 1", bus.ramREN); end
    next_cycle();
    bus.ramstate = ACCESS;
    #1;
    tests_run++; if (bus.iwait !== 1'b0) begin tests_failed++; $display("FAIL simul_i_iwait got %b want 0", bus.iwait); end
    next_cycle();
    bus.iREN = 1'b0; bus.ramstate = FREE;
  endtask

  task automatic test_write();
    @(negedge clk);
    bus.dREN = 1'b1; bus.dWEN = 1'b1; bus.daddr = 32'h300; bus.dstore = 32'hDEADBEEF;
    next_cycle();
    bus.ramstate = BUSY;
    #1;
    tests_run++; if (bus.ramWEN !== 1'b1) begin tests_failed++; $display("FAIL write_ramWEN got %b want 1", bus.ramWEN); end
    tests_run++; if (bus.ramREN !== 1'b0) begin tests_failed++; $display("FAIL write_ramREN got %b want 0", bus.ramREN); end
    tests_run++; if (bus.ramstore !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL write_ramstore got %h want deadbeef", bus.ramstore); end
    tests_run++; if (bus.ramaddr !== 32'h300) begin tests_failed++; $display("FAIL write_ramaddr got %h want 300", bus.ramaddr); end
    next_cycle();
    bus.ramstate = ACCESS;
    #1;
    tests_run++; if (bus.dwait !== 1'b0) begin tests_failed++; $display("FAIL write_dwait got %b want 0", bus.dwait); end
    next_cycle();
    bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.ramstate = FREE;
    #1;
    tests_run++; if (bus.ramWEN !== 1'b0) begin tests_failed++; $display("FAIL write_idle_ramWEN got %b want 0", bus.ramWEN); end
  endtask

  task automatic test_error();
    @(negedge clk);
    bus.dREN = 1'b1; bus.daddr = 32'h400;
    next_cycle();
    bus.ramstate = ERROR;
    #1;
    tests_run++; if (bus.memfault !== 1'b1) begin tests_failed++; $display("FAIL err_memfault got %b want 1", bus.memfault); end
    tests_run++; if (bus.dwait !== 1'b1) begin tests_failed++; $display("FAIL err_dwait got %b want 1", bus.dwait); end
    next_cycle();
    bus.ramstate = FREE;
    #1;
    tests_run++; if (bus.rambusy !== 1'b0) begin tests_failed++; $display("FAIL err_idle_rambusy got %b want 0", bus.rambusy); end
    tests_run++; if (bus.memfault !== 1'b0) begin tests_failed++; $display("FAIL err_pulse_len got %b want 0", bus.memfault); end
    tests_run++; if (bus.dwait !== 1'b1) begin tests_failed++; $display("FAIL err_idle_dwait got %b want 1", bus.dwait); end
    next_cycle();
    bus.ramstate = ACCESS;
    #1;
    tests_run++; if (bus.ramaddr !== 32'h400) begin tests_failed++; $display("FAIL err_regrant_ramaddr got %h want 400", bus.ramaddr); end
    tests_run++; if (bus.dwait !== 1'b0) begin tests_failed++; $display("FAIL err_regrant_dwait got %b want 0", bus.dwait); end
    next_cycle();
    bus.dREN = 1'b0; bus.ramstate = FREE;
  endtask

  // Fetch is failed with ERROR after each data completion, so the arbiter
  // keeps coming back through IDLE with both sides requesting.
  task automatic test_starvation();
    @(negedge clk);
    bus.iREN = 1'b1; bus.iaddr = 32'h500; bus.dREN = 1'b1; bus.daddr = 32'h600;
    for (int k = 0; k < MAXD; k++) begin
      next_cycle();
      bus.ramstate = ACCESS;
      #1;
      tests_run++; if (bus.ramaddr !== 32'h600) begin tests_failed++; $display("FAIL starve_d%0d_ramaddr got %h want 600", k, bus.ramaddr); end
      next_cycle();
      bus.ramstate = ERROR;
      #1;
      tests_run++; if (bus.ramaddr !== 32'h500) begin tests_failed++; $display("FAIL starve_i%0d_ramaddr got %h want 500", k, bus.ramaddr); end
      next_cycle();
      bus.ramstate = FREE;
      #1;
      tests_run++; if (bus.rambusy !== 1'b0) begin tests_failed++; $display("FAIL starve_idle%0d_rambusy got %b want 0", k, bus.rambusy); end
    end
    next_cycle();
    bus.ramstate = ACCESS;
    #1;
    tests_run++; if (bus.ramaddr !== 32'h500) begin tests_failed++; $display("FAIL starve_forced_i_ramaddr got %h want 500", bus.ramaddr); end
    tests_run++; if (bus.iwait !== 1'b0) begin tests_failed++; $display("FAIL starve_forced_i_iwait got %b want 0", bus.iwait); end
    next_cycle();
    bus.ramstate = ERROR;
    #1;
    tests_run++; if (bus.ramaddr !== 32'h600) begin tests_failed++; $display("FAIL starve_after_i_ramaddr got %h want 600", bus.ramaddr); end
    next_cycle();
    bus.ramstate = FREE;
    next_cycle();
    bus.ramstate = ACCESS;
    #1;
    tests_run++; if (bus.ramaddr !== 32'h600) begin tests_failed++; $display("FAIL starve_cleared_ramaddr got %h want 600", bus.ramaddr); end
    next_cycle();
    bus.dREN = 1'b0; bus.ramstate = ACCESS;
    #1;
    tests_run++; if (bus.ramaddr !== 32'h500) begin tests_failed++; $display("FAIL starve_tail_ramaddr got %h want 500", bus.ramaddr); end
    next_cycle();
    bus.iREN = 1'b0; bus.ramstate = FREE;
  endtask

  task automatic test_midgrant_reset();
    @(negedge clk);
    bus.iREN = 1'b1; bus.iaddr = 32'h700;
    next_cycle();
    bus.ramstate = BUSY;
    #1;
    tests_run++; if (bus.ramREN !== 1'b1) begin tests_failed++; $display("FAIL mrst_grant_ramREN got %b want 1", bus.ramREN); end
    bus.sRST = 1'b1;
    next_cycle();
    #1;
    tests_run++; if (bus.ramREN !== 1'b0) begin tests_failed++; $display("FAIL mrst_ramREN got %b want 0", bus.ramREN); end
    tests_run++; if (bus.rambusy !== 1'b0) begin tests_failed++; $display("FAIL mrst_rambusy got %b want 0", bus.rambusy); end
    tests_run++; if (bus.iwait !== 1'b1) begin tests_failed++; $display("FAIL mrst_iwait got %b want 1", bus.iwait); end
    bus.sRST = 1'b0;
    next_cycle();
    bus.ramstate = ACCESS;
    #1;
    tests_run++; if (bus.ramaddr !== 32'h700) begin tests_failed++; $display("FAIL mrst_resume_ramaddr got %h want 700", bus.ramaddr); end
    tests_run++; if (bus.iwait !== 1'b0) begin tests_failed++; $display("FAIL mrst_resume_iwait got %b want 0", bus.iwait); end
    next_cycle();
    bus.iREN = 1'b0; bus.ramstate = FREE;
  endtask

  // Randomized traffic against a reference model: owner 0 = none,
  // 1 = fetch, 2 = data; streak counts data wins held against a fetch.
  task automatic test_random();
    int    own, streak;
    bit    i_fin, d_fin, dreq, acc, err;
    bit    e_ren, e_wen, e_iwait, e_dwait, e_busy, e_fault;
    word_t e_addr, e_store, e_iload, e_dload;
    int    r;
    own = 0; streak = 0; i_fin = 0; d_fin = 0;
    @(negedge clk);
    bus.sRST = 1'b1; bus.iREN = 1'b0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
    next_cycle();
    bus.sRST = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (!bus.iREN || i_fin) begin
        bus.iREN = ($urandom_range(0, 2) == 0);
        bus.iaddr = $urandom;
      end else if ($urandom_range(0, 39) == 0) begin
        bus.iREN = 1'b0;
      end
      if (!(bus.dREN || bus.dWEN) || d_fin) begin
        if ($urandom_range(0, 2) == 0) begin
          r = $urandom_range(0, 2);
          bus.dREN = (r != 1); bus.dWEN = (r != 0);
        end else begin
          bus.dREN = 1'b0; bus.dWEN = 1'b0;
        end
        bus.daddr = $urandom; bus.dstore = $urandom;
      end else if ($urandom_range(0, 39) == 0) begin
        bus.dREN = 1'b0; bus.dWEN = 1'b0;
      end
      r = $urandom_range(0, 9);
      bus.ramstate = (r < 5) ? ACCESS : (r < 8) ? BUSY : (r < 9) ? ERROR : FREE;
      bus.ramload = $urandom;
      bus.sRST = ($urandom_range(0, 99) == 0);
      #1;
      dreq = bus.dREN || bus.dWEN;
      acc  = (bus.ramstate == ACCESS);
      err  = (bus.ramstate == ERROR);
      e_ren   = (own == 1) || (own == 2 && bus.dREN && !bus.dWEN);
      e_wen   = (own == 2) && bus.dWEN;
      e_addr  = (own == 1) ? bus.iaddr : (own == 2) ? bus.daddr : 32'h0;
      e_store = (own == 2) ? bus.dstore : 32'h0;
      e_iwait = bus.iREN && !(own == 1 && acc);
      e_dwait = dreq && !(own == 2 && acc);
      e_iload = (own == 1 && acc) ? bus.ramload : 32'h0;
      e_dload = (own == 2 && acc) ? bus.ramload : 32'h0;
      e_busy  = (own != 0);
      e_fault = (own != 0) && err && !bus.sRST;
      tests_run++; if (bus.ramREN !== e_ren) begin tests_failed++; $display("FAIL rand%0d_ramREN got %b want %b", cyc, bus.ramREN, e_ren); end
      tests_run++; if (bus.ramWEN !== e_wen) begin tests_failed++; $display("FAIL rand%0d_ramWEN got %b want %b", cyc, bus.ramWEN, e_wen); end
      tests_run++; if (bus.ramaddr !== e_addr) begin tests_failed++; $display("FAIL rand%0d_ramaddr got %h want %h", cyc, bus.ramaddr, e_addr); end
      tests_run++; if (bus.ramstore !== e_store) begin tests_failed++; $display("FAIL rand%0d_ramstore got %h want %h", cyc, bus.ramstore, e_store); end
      tests_run++; if (bus.iwait !== e_iwait) begin tests_failed++; $display("FAIL rand%0d_iwait got %b want %b", cyc, bus.iwait, e_iwait); end
      tests_run++; if (bus.dwait !== e_dwait) begin tests_failed++; $display("FAIL rand%0d_dwait got %b want %b", cyc, bus.dwait, e_dwait); end
      tests_run++; if (bus.iload !== e_iload) begin tests_failed++; $display("FAIL rand%0d_iload got %h want %h", cyc, bus.iload, e_iload); end
      tests_run++; if (bus.dload !== e_dload) begin tests_failed++; $display("FAIL rand%0d_dload got %h want %h", cyc, bus.dload, e_dload); end
      tests_run++; if (bus.rambusy !== e_busy) begin tests_failed++; $display("FAIL rand%0d_rambusy got %b want %b", cyc, bus.rambusy, e_busy); end
      tests_run++; if (bus.memfault !== e_fault) begin tests_failed++; $display("FAIL rand%0d_memfault got %b want %b", cyc, bus.memfault, e_fault); end
      i_fin = (own == 1) && acc;
      d_fin = (own == 2) && acc;
      if (bus.sRST) begin
        own = 0; streak = 0;
      end else if (own == 0) begin
        if (dreq && (streak < MAXD || !bus.iREN)) own = 2;
        else if (bus.iREN) own = 1;
      end else if (err) begin
        own = 0;
      end else if (acc && own == 1) begin
        streak = 0;
        own = dreq ? 2 : 0;
      end else if (acc) begin
        streak = bus.iREN ? ((streak < MAXD) ? streak + 1 : MAXD) : 0;
        own = bus.iREN ? 1 : 0;
      end else if ((own == 1 && !bus.iREN) || (own == 2 && !dreq)) begin
        own = 0;
      end
      next_cycle();
    end
    bus.iREN = 1'b0; bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.sRST = 1'b0;
    bus.ramstate = FREE;
  endtask

  initial begin
    bus.sRST = 1'b1; bus.iREN = 1'b0; bus.iaddr = '0; bus.dREN = 1'b0;
    bus.dWEN = 1'b0; bus.daddr = '0; bus.dstore = '0; bus.ramstate = FREE;
    bus.ramload = '0;
    repeat (2) @(posedge clk);
    test_reset();
    test_fetch_only();
    test_simultaneous();
    test_write();
    test_error();
    test_starvation();
    test_midgrant_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_ram_arbiter
`default_nettype wire
